// File: rtl/case3_pkg.sv
// Shared types and constants for the case3 exhaustive vector sweeper.
// Holds the FSM encoding, bus widths and the MISR polynomial/seed.
package case3_pkg;

  localparam int VEC_W = 7;
  localparam int RES_W = 3;
  localparam int SIG_W = 16;
  localparam int CNT_W = 8;

  localparam logic [SIG_W-1:0] MISR_POLY = 16'h1021;
  localparam logic [SIG_W-1:0] MISR_SEED = 16'hFFFF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_APPLY,
    S_SAMPLE,
    S_DONE
  } state_t;

  // One MISR step: shift left, fold the feedback polynomial, inject the result bits.
  function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] s,
                                                 input logic [RES_W-1:0] d);
    logic [SIG_W-1:0] fb;
    fb = s[SIG_W-1] ? MISR_POLY : '0;
    return {s[SIG_W-2:0], 1'b0} ^ fb ^ {{(SIG_W-RES_W){1'b0}}, d};
  endfunction

endpackage

// File: rtl/case3_misr.sv
// 16-bit multiple-input signature register over the three case3 result bits.
// seed reloads the start value and wins over en; state changes one cycle after the request.
module case3_misr
  import case3_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             seed,
  input  logic             en,
  input  logic [RES_W-1:0] d,
  output logic [SIG_W-1:0] sig
);

  logic [SIG_W-1:0] sig_q;
  logic [SIG_W-1:0] sig_d;

  always_comb begin
    sig_d = sig_q;
    if (seed) begin
      sig_d = MISR_SEED;
    end else if (en) begin
      sig_d = misr_step(sig_q, d);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q <= MISR_SEED;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/case3_vector_sweeper.sv
// Walks all 128 input vectors through an external case3 netlist, compacting results into a MISR
// and per-bit one counts; each vector takes SETTLE+1 cycles, abort returns to IDLE silently.
module case3_vector_sweeper
  import case3_pkg::*;
#(
  parameter int unsigned      SETTLE     = 1,
  parameter logic [SIG_W-1:0] GOLDEN_SIG = 16'h0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic [VEC_W-1:0] vec_out,
  input  logic [RES_W-1:0] res_in,
  output logic             busy,
  output logic             done,
  output logic [SIG_W-1:0] signature,
  output logic [CNT_W-1:0] x_count,
  output logic [CNT_W-1:0] y_count,
  output logic [CNT_W-1:0] z_count,
  output logic             pass
);

  localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [VEC_W-1:0] VEC_LAST    = '1;

  state_t           state_q, state_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic [3:0]       set_q, set_d;
  logic [CNT_W-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic             valid_q, valid_d;
  logic             misr_seed, misr_en;

  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    set_d     = set_q;
    x_d       = x_q;
    y_d       = y_q;
    z_d       = z_q;
    valid_d   = valid_q;
    misr_seed = 1'b0;
    misr_en   = 1'b0;
    if (abort) begin
      // Partial results are kept for inspection, but never qualify as a pass.
      state_d = S_IDLE;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d   = S_APPLY;
            vec_d     = '0;
            set_d     = '0;
            x_d       = '0;
            y_d       = '0;
            z_d       = '0;
            valid_d   = 1'b0;
            misr_seed = 1'b1;
          end
        end
        S_APPLY: begin
          if (set_q == SETTLE_LAST) begin
            state_d = S_SAMPLE;
          end else begin
            set_d = set_q + 4'd1;
          end
        end
        S_SAMPLE: begin
          misr_en = 1'b1;
          x_d     = x_q + {{(CNT_W-1){1'b0}}, res_in[2]};
          y_d     = y_q + {{(CNT_W-1){1'b0}}, res_in[1]};
          z_d     = z_q + {{(CNT_W-1){1'b0}}, res_in[0]};
          if (vec_q == VEC_LAST) begin
            state_d = S_DONE;
            valid_d = 1'b1;
          end else begin
            state_d = S_APPLY;
            vec_d   = vec_q + 7'd1;
            set_d   = '0;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      set_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      set_q   <= set_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      valid_q <= valid_d;
    end
  end

  case3_misr u_misr (
    .clk  (clk),
    .rst  (rst),
    .seed (misr_seed),
    .en   (misr_en),
    .d    (res_in),
    .sig  (signature)
  );

  assign vec_out = vec_q;
  assign busy    = (state_q == S_APPLY) || (state_q == S_SAMPLE);
  assign done    = (state_q == S_DONE);
  assign x_count = x_q;
  assign y_count = y_q;
  assign z_count = z_q;
  assign pass    = valid_q && (signature == GOLDEN_SIG);

endmodule

// File: doc/case3_vector_sweeper.md
CASE3_VECTOR_SWEEPER -- requirements
Module: case3_vector_sweeper

Interface
REQ-001 SHALL have parameter SETTLE, default 1: cycles each vector is held on vec_out before res_in is sampled (range 1..15).
REQ-002 SHALL have parameter GOLDEN_SIG, default 16'h0000: expected final signature used for pass.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: one-cycle request to begin a full sweep.
REQ-006 SHALL have port abort, input, 1 bit: terminates a sweep in progress.
REQ-007 SHALL have port vec_out, output, 7 bits: drives the downstream case3 netlist; bit6..bit0 = a,b,c,d,e,f,g.
REQ-008 SHALL have port res_in, input, 3 bits: case3 results; bit2..bit0 = x,y,z.
REQ-009 SHALL have port busy, output, 1 bit: high in APPLY and SAMPLE.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse on sweep completion.
REQ-011 SHALL have port signature, output, 16 bits: MISR result.
REQ-012 SHALL have ports x_count, y_count, z_count, output, 8 bits each: count of sampled ones per result bit.
REQ-013 SHALL have port pass, output, 1 bit: signature == GOLDEN_SIG, valid from the done pulse until the next start.

Function
REQ-014 SHALL implement the states IDLE, APPLY, SAMPLE and DONE.
REQ-015 IDLE + start SHALL go to APPLY next cycle with vec_out=0, counts cleared, signature seeded to 16'hFFFF.
REQ-016 APPLY SHALL hold vec_out stable for SETTLE cycles, then go to SAMPLE.
REQ-017 SAMPLE (one cycle) SHALL capture res_in, update counts and MISR, then go to APPLY with vec_out+1, or to DONE if vec_out==127.
REQ-018 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-019 Sweep latency SHALL be 128*(SETTLE+1) cycles from the first APPLY cycle to the DONE cycle.
REQ-020 MISR update SHALL be sig_next = {sig[14:0],1'b0} ^ (sig[15] ? 16'h1021 : 0) ^ {13'b0,res_in}.
REQ-021 Counts SHALL increment by the respective res_in bit in SAMPLE; 8 bits suffice (maximum 128), so counts never wrap.
REQ-022 start while busy or in DONE SHALL be ignored.
REQ-023 abort SHALL take priority over start and sweep progression, forcing IDLE next cycle with no done pulse.
REQ-024 After abort, counts and signature SHALL hold their partial values and pass SHALL be 0.
REQ-025 start and abort in the same IDLE cycle SHALL leave the block in IDLE.
REQ-026 In IDLE and DONE, vec_out SHALL hold its last driven value.
REQ-027 Results (signature, counts, pass) SHALL remain stable from DONE until the next accepted start.

Reset
REQ-028 rst SHALL force state=IDLE, vec_out=0, busy=0, done=0, signature=16'hFFFF, counts=0, pass=0.
REQ-029 rst SHALL take priority over abort and start, including in the middle of a sweep.

Structure
REQ-030 Package case3_pkg SHALL hold the state enum, VEC_W=7, RES_W=3, MISR_POLY=16'h1021 and MISR_SEED=16'hFFFF.
REQ-031 The MISR SHALL be a sub-module case3_misr (ports: clk, rst, seed, en, d[2:0], sig[15:0]).

Verification
REQ-032 Connect case3, pulse start with SETTLE=1 -> done at cycle 256 after the first APPLY; x_count=4, y_count=120, z_count=64.
REQ-033 Same sweep -> signature equals the reference-model MISR over all 128 vectors; with GOLDEN_SIG set to that value, pass=1, and with any other value, pass=0.
REQ-034 SETTLE=3, apply an X-glitch on res_in during non-sample cycles -> counts and signature unchanged versus the REQ-032 run.
REQ-035 abort at vector 50 -> IDLE next cycle, no done pulse, pass=0; a new start then yields the full REQ-032 results.
REQ-036 start pulses during busy, plus rst asserted at vector 90 -> starts ignored; after rst, all REQ-028 values, state IDLE.
REQ-037 start and abort asserted together in IDLE -> remains IDLE, busy stays 0.
